ctrl_flow_redirect: RTL and testbench
=====================================

CTRL_FLOW_REDIRECT -- requirements
Module: ctrl_flow_redirect

Interface
REQ-001 SHALL have parameter SQUASH_CYCLES, default 1, wrong-path slots killed after each redirect (legal 1..3).
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pc  in  32  word address of the instruction presented on instr.
REQ-006 SHALL have port instr  in  32  fetched instruction word.
REQ-007 SHALL have port instr_valid  in  1  instr/pc valid this cycle.
REQ-008 SHALL have port rs_data, rt_data  in  32 each  register operands for instr.
REQ-009 SHALL have ports isJR, jump, pcsel  out  1 each  redirect strobes to the PC register.
REQ-010 SHALL have ports jr_address, jump_address, branch_offset  out  32 each  redirect targets/offset.
REQ-011 SHALL have port issue_ok  out  1  instr is on the correct path and may be executed.
REQ-012 SHALL have ports link_we  out  1, link_data  out  32  write pc+1 to register 31 (JAL).
REQ-013 SHALL have ports redirect_cnt, squash_cnt  out  CNT_W each  statistics.

Function
REQ-014 SHALL decode: J op 6'h02, JAL 6'h03, BEQ 6'h04, BNE 6'h05, JR op 6'h00 with funct 6'h08.
REQ-015 SHALL drive jump_address = {pc[31:26], instr[25:0]} (word addressing), combinationally.
REQ-016 SHALL drive branch_offset = sign-extend(instr[15:0]), unshifted, combinationally.
REQ-017 SHALL drive jr_address = rs_data, combinationally.
REQ-018 SHALL compute a branch as taken when BEQ and rs_data==rt_data, or BNE and rs_data!=rt_data (full 32-bit compare).
REQ-019 SHALL implement a two-state FSM: RUN, SQUASH; a cycle is "live" when state==RUN and instr_valid==1.
REQ-020 SHALL, in a live cycle, assert isJR for JR, jump for J/JAL, pcsel for a taken branch; at most one strobe high.
REQ-021 SHALL keep all three strobes low in any non-live cycle, regardless of instr contents.
REQ-022 SHALL drive issue_ok = live; link_we = live AND JAL; link_data = pc + 1 (32-bit wrap).
REQ-023 SHALL, on any strobe in a live cycle, move RUN->SQUASH and load the squash counter with SQUASH_CYCLES.
REQ-024 SHALL, in SQUASH, decrement the squash counter only on instr_valid==1 cycles, and return to RUN on the cycle the counter reaches 0.
REQ-025 SHALL hold state and counter unchanged when instr_valid==0.
REQ-026 SHALL increment redirect_cnt on each strobe cycle and squash_cnt on each SQUASH cycle with instr_valid==1; both saturate at all-ones.
REQ-027 SHALL treat a not-taken branch as non-redirecting: no strobe, remain in RUN.
REQ-028 SHALL treat a redirect whose target equals pc+1 identically to any other redirect (squash still applied).

Reset
REQ-029 SHALL on reset force state=RUN, squash counter=0, redirect_cnt=0, squash_cnt=0.
REQ-030 SHALL, while reset is high, hold isJR, jump, pcsel, issue_ok, link_we at 0; target outputs remain combinational.
REQ-031 SHALL abandon a SQUASH in progress on reset; the first valid instruction after deassertion is live.

Structure
REQ-032 SHALL take opcode/funct constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, FN_JR) and the FSM state encoding from the shared CPU package.
REQ-033 SHALL contain one sub-module, sat_counter (width parameter, increment enable, saturating), instantiated twice.

Verification
REQ-034 SHALL check BEQ pc=10, imm=16'hFFFC, rs=rt=5 -> pcsel=1, branch_offset=32'hFFFFFFFC, next valid cycle issue_ok=0, the one after issue_ok=1.
REQ-035 SHALL check BNE with rs=rt=7 -> no strobe, issue_ok=1, state stays RUN, redirect_cnt unchanged.
REQ-036 SHALL check JAL pc=32'h0400_0020, instr[25:0]=26'h0000100 -> jump=1, jump_address=32'h0400_0100, link_we=1, link_data=32'h0400_0021.
REQ-037 SHALL check JR rs=32'h1234 with SQUASH_CYCLES=2 and instr_valid gapped (1,0,1) after it -> isJR=1, jr_address=32'h1234, two valid squashed slots with issue_ok=0, counter frozen in the gap.
REQ-038 SHALL check a J arriving during SQUASH -> no strobe; reset asserted mid-SQUASH -> next valid J strobes jump=1.
REQ-039 SHALL check CNT_W=4 with 20 redirects -> redirect_cnt saturates at 4'hF.

Source files
------------

// File: rtl/ctrl_flow_redirect_pkg.sv
// ctrl_flow_redirect_pkg
// Shared CPU constants for the redirect controller. It holds the opcode and
// funct encodings, the squash FSM state encoding, the width of the squash
// counter, and a sign-extension helper.
package ctrl_flow_redirect_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_JR    = 6'h08;

    // The squash counter only needs to hold 1..3.
    localparam int SQ_W = 2;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

    // Sign-extend a 16-bit immediate to 32 bits without shifting it.
    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/ctrl_flow_redirect_sat_counter.sv
// sat_counter
// This is a statistics counter. It increments by one on each enabled cycle
// and stops at all-ones.
// Ports: clk, reset (async, active-high), i_inc (increment enable),
//        o_count [W-1:0] (current count, registered).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Saturating increment; holds the count once it reaches all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= {W{1'b0}};
        end else if (i_inc && !(&r_count)) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ctrl_flow_redirect.sv
// ctrl_flow_redirect
// Decodes J, JAL, JR, BEQ and BNE and raises one redirect strobe toward the
// PC register. After each redirect it kills SQUASH_CYCLES valid wrong-path
// slots.
// Ports:
//   clk, reset (async, active-high)
//   pc, instr, instr_valid, rs_data, rt_data : the current fetch slot
//   isJR, jump, pcsel                        : redirect strobes
//   jr_address, jump_address, branch_offset  : redirect targets (combinational)
//   issue_ok                                 : the slot is on the correct path
//   link_we, link_data                       : JAL writes pc+1 to r31
//   redirect_cnt, squash_cnt                 : saturating statistics
module ctrl_flow_redirect
    import ctrl_flow_redirect_pkg::*;
#(
    parameter int SQUASH_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic             isJR,
    output logic             jump,
    output logic             pcsel,
    output logic [31:0]      jr_address,
    output logic [31:0]      jump_address,
    output logic [31:0]      branch_offset,
    output logic             issue_ok,
    output logic             link_we,
    output logic [31:0]      link_data,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    state_e          r_state;
    logic [SQ_W-1:0] r_sq_cnt;

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_live;
    logic       w_is_jr;
    logic       w_is_j;
    logic       w_taken;
    logic       w_strobe;
    logic       w_sq_inc;

    assign w_op = instr[31:26];
    assign w_fn = instr[5:0];

    // A live slot is a valid slot in RUN. Reset is included here so that all
    // strobes stay low while reset is held.
    assign w_live = !reset && (r_state == ST_RUN) && instr_valid;

    assign w_is_jr  = (w_op == OP_RTYPE) && (w_fn == FN_JR);
    assign w_is_j   = (w_op == OP_J) || (w_op == OP_JAL);
    assign w_taken  = ((w_op == OP_BEQ) && (rs_data == rt_data)) ||
                      ((w_op == OP_BNE) && (rs_data != rt_data));

    assign isJR     = w_live && w_is_jr;
    assign jump     = w_live && w_is_j;
    assign pcsel    = w_live && w_taken;
    assign w_strobe = isJR || jump || pcsel;

    assign issue_ok  = w_live;
    assign link_we   = w_live && (w_op == OP_JAL);
    assign link_data = pc + 32'd1;

    assign jr_address    = rs_data;
    assign jump_address  = {pc[31:26], instr[25:0]};
    assign branch_offset = sign_ext16(instr[15:0]);

    assign w_sq_inc = !reset && (r_state == ST_SQUASH) && instr_valid;

    // Squash FSM. Only valid slots advance it, so gaps do not use up
    // squash slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_sq_cnt <= {SQ_W{1'b0}};
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_strobe) begin
                        r_state  <= ST_SQUASH;
                        r_sq_cnt <= SQ_W'(SQUASH_CYCLES);
                    end else begin
                        r_state  <= ST_RUN;
                        r_sq_cnt <= r_sq_cnt;
                    end
                end
                ST_SQUASH: begin
                    if (!instr_valid) begin
                        r_state  <= ST_SQUASH;
                        r_sq_cnt <= r_sq_cnt;
                    end else if (r_sq_cnt <= 2'd1) begin
                        // This is the last squashed slot; the next valid slot is live.
                        r_state  <= ST_RUN;
                        r_sq_cnt <= {SQ_W{1'b0}};
                    end else begin
                        r_state  <= ST_SQUASH;
                        r_sq_cnt <= r_sq_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_sq_cnt <= {SQ_W{1'b0}};
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_strobe),
        .o_count (redirect_cnt)
    );

    sat_counter #(.W(CNT_W)) u_squash_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_sq_inc),
        .o_count (squash_cnt)
    );

endmodule

// File: tb/tb_ctrl_flow_redirect.sv
// tb_ctrl_flow_redirect
// Two instances receive the same stimulus. Instance 0 uses SQUASH_CYCLES=1
// and CNT_W=4. Instance 1 uses SQUASH_CYCLES=2 and CNT_W=16. For every slot,
// a behavioural model pushes the expected outputs into a queue. They are
// popped and compared on the falling edge.
module tb_ctrl_flow_redirect;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, instr, rs_data, rt_data;
    logic        instr_valid;

    logic        isjr [2];
    logic        jmp  [2];
    logic        psel [2];
    logic        iok  [2];
    logic        lwe  [2];
    logic [31:0] jra  [2];
    logic [31:0] ja   [2];
    logic [31:0] bo   [2];
    logic [31:0] ld   [2];
    logic [3:0]  red0, sq0;
    logic [15:0] red1, sq1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_flow_redirect #(.SQUASH_CYCLES(1), .CNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .rs_data(rs_data), .rt_data(rt_data), .isJR(isjr[0]), .jump(jmp[0]), .pcsel(psel[0]),
        .jr_address(jra[0]), .jump_address(ja[0]), .branch_offset(bo[0]), .issue_ok(iok[0]),
        .link_we(lwe[0]), .link_data(ld[0]), .redirect_cnt(red0), .squash_cnt(sq0));

    ctrl_flow_redirect #(.SQUASH_CYCLES(2), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .rs_data(rs_data), .rt_data(rt_data), .isJR(isjr[1]), .jump(jmp[1]), .pcsel(psel[1]),
        .jr_address(jra[1]), .jump_address(ja[1]), .branch_offset(bo[1]), .issue_ok(iok[1]),
        .link_we(lwe[1]), .link_data(ld[1]), .redirect_cnt(red1), .squash_cnt(sq1));

    // Behavioural model state, one entry per instance.
    int  m_squash [2];
    int  m_left   [2];
    int  m_red    [2];
    int  m_sq     [2];
    int  sq_len   [2] = '{1, 2};
    int  sat_max  [2] = '{15, 65535};

    typedef struct {
        logic [2:0]  strobes [2];
        logic        issue   [2];
        logic        lwe_e   [2];
        int          red     [2];
        int          sq      [2];
        logic [31:0] jr_a, j_a, b_o, l_d;
    } exp_t;

    exp_t sb[$];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected {isJR, jump, pcsel} for one instance, given the current inputs.
    function automatic logic [2:0] model_strobes(input int k);
        logic       live;
        logic [5:0] op;
        op   = instr[31:26];
        live = !reset && (m_squash[k] == 0) && instr_valid;
        return {live && op == 6'h00 && instr[5:0] == 6'h08,
                live && (op == 6'h02 || op == 6'h03),
                live && ((op == 6'h04 && rs_data == rt_data) ||
                         (op == 6'h05 && rs_data != rt_data))};
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.strobes[k] = model_strobes(k);
            e.issue[k]   = !reset && (m_squash[k] == 0) && instr_valid;
            e.lwe_e[k]   = e.issue[k] && (instr[31:26] == 6'h03);
            e.red[k]     = m_red[k];
            e.sq[k]      = m_sq[k];
        end
        e.jr_a = rs_data;
        e.j_a  = {pc[31:26], instr[25:0]};
        e.b_o  = {{16{instr[15]}}, instr[15:0]};
        e.l_d  = pc + 32'd1;
        return e;
    endfunction

    task automatic model_zero();
        for (int k = 0; k < 2; k++) begin
            m_squash[k] = 0; m_left[k] = 0; m_red[k] = 0; m_sq[k] = 0;
        end
    endtask

    // Advance the model across one rising edge.
    task automatic model_tick();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_squash[k] = 0; m_left[k] = 0; m_red[k] = 0; m_sq[k] = 0;
            end else if (m_squash[k] == 0) begin
                if (model_strobes(k) != 3'b000) begin
                    m_squash[k] = 1;
                    m_left[k]   = sq_len[k];
                    if (m_red[k] < sat_max[k]) m_red[k]++;
                end
            end else if (instr_valid) begin
                if (m_sq[k] < sat_max[k]) m_sq[k]++;
                m_left[k]--;
                if (m_left[k] == 0) m_squash[k] = 0;
            end
        end
    endtask

    task automatic step(input logic v, input logic [31:0] p, input logic [31:0] i,
                        input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        instr_valid = v; pc = p; instr = i; rs_data = a; rt_data = b;
        sb.push_back(model_expect());
        @(negedge clk);
        e = sb.pop_front();
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("strobes%0d", k), {61'd0, isjr[k], jmp[k], psel[k]}, {61'd0, e.strobes[k]});
            check_val($sformatf("issue_ok%0d", k), {63'd0, iok[k]}, {63'd0, e.issue[k]});
            check_val($sformatf("link_we%0d", k), {63'd0, lwe[k]}, {63'd0, e.lwe_e[k]});
            check_val($sformatf("jr_addr%0d", k), {32'd0, jra[k]}, {32'd0, e.jr_a});
            check_val($sformatf("jump_addr%0d", k), {32'd0, ja[k]}, {32'd0, e.j_a});
            check_val($sformatf("br_off%0d", k), {32'd0, bo[k]}, {32'd0, e.b_o});
            check_val($sformatf("link_data%0d", k), {32'd0, ld[k]}, {32'd0, e.l_d});
        end
        check_val("redirect_cnt0", {60'd0, red0}, 64'(e.red[0]));
        check_val("squash_cnt0",   {60'd0, sq0},  64'(e.sq[0]));
        check_val("redirect_cnt1", {48'd0, red1}, 64'(e.red[1]));
        check_val("squash_cnt1",   {48'd0, sq1},  64'(e.sq[1]));
        @(posedge clk);
        model_tick();
        #1;
    endtask

    function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    function automatic logic [31:0] mk_br(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] JR  = 32'h03E0_0008;

    initial begin
        reset = 1'b1; instr_valid = 1'b0; pc = 32'd0; instr = NOP; rs_data = 32'd0; rt_data = 32'd0;
        model_zero();
        @(posedge clk); #1;
        // Reset held: a valid J must not strobe, and the counters read zero.
        step(1'b1, 32'd4, mk_j(6'h02, 26'h10), 32'd0, 32'd0);
        reset = 1'b0;

        // Taken BEQ with a negative offset.
        step(1'b1, 32'd10, mk_br(6'h04, 16'hFFFC), 32'd5, 32'd5);
        check_val("beq_off_lit", {32'd0, bo[0]}, 64'h0000_0000_FFFF_FFFC);
        step(1'b1, 32'd11, NOP, 32'd0, 32'd0);
        step(1'b1, 32'd12, NOP, 32'd0, 32'd0);
        step(1'b1, 32'd13, NOP, 32'd0, 32'd0);

        // BNE with equal operands is not taken. A BEQ with different
        // operands is not taken either. A BNE with different operands is taken.
        step(1'b1, 32'd20, mk_br(6'h05, 16'h0004), 32'd7, 32'd7);
        step(1'b1, 32'd21, mk_br(6'h04, 16'h0004), 32'd7, 32'h8000_0007);
        step(1'b1, 32'd22, mk_br(6'h05, 16'h7FFF), 32'd1, 32'd2);
        step(1'b1, 32'd23, NOP, 32'd0, 32'd0);
        step(1'b1, 32'd24, NOP, 32'd0, 32'd0);

        // JAL with link.
        step(1'b1, 32'h0400_0020, mk_j(6'h03, 26'h0000100), 32'd0, 32'd0);
        step(1'b1, 32'h0400_0021, NOP, 32'd0, 32'd0);
        step(1'b1, 32'h0400_0022, NOP, 32'd0, 32'd0);

        // JR, then slots with valid = 1,0,1,1 to exercise the squash gap.
        step(1'b1, 32'd40, JR, 32'h1234, 32'd0);
        step(1'b1, 32'd41, NOP, 32'd0, 32'd0);
        step(1'b0, 32'd42, NOP, 32'd0, 32'd0);
        step(1'b1, 32'd42, NOP, 32'd0, 32'd0);
        step(1'b1, 32'd43, NOP, 32'd0, 32'd0);

        // A J that arrives during SQUASH must not strobe.
        step(1'b1, 32'd50, mk_j(6'h02, 26'h80), 32'd0, 32'd0);
        step(1'b1, 32'd51, mk_j(6'h02, 26'h90), 32'd0, 32'd0);
        // Reset mid-SQUASH (instance 1 is still squashing); the next J is live.
        reset = 1'b1;
        model_zero();
        step(1'b1, 32'd52, mk_j(6'h02, 26'h90), 32'd0, 32'd0);
        reset = 1'b0;
        step(1'b1, 32'd53, mk_j(6'h02, 26'hA0), 32'd0, 32'd0);
        step(1'b1, 32'd54, NOP, 32'd0, 32'd0);
        step(1'b1, 32'd55, NOP, 32'd0, 32'd0);

        // A redirect whose target is pc+1 is still squashed.
        step(1'b1, 32'd60, mk_j(6'h02, 26'd61), 32'd0, 32'd0);
        step(1'b1, 32'd61, NOP, 32'd0, 32'd0);
        step(1'b1, 32'd62, NOP, 32'd0, 32'd0);

        // 20 redirects saturate the 4-bit counters of instance 0.
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 32'd100 + 32'(n), mk_j(6'h02, 26'(n)), 32'd0, 32'd0);
            step(1'b1, 32'd200, NOP, 32'd0, 32'd0);
            step(1'b1, 32'd201, NOP, 32'd0, 32'd0);
        end
        check_val("redirect_sat_lit", {60'd0, red0}, 64'h0000_0000_0000_000F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
